// File: rtl/float_to_int_rnd.sv
// IEEE-754 float to integer converter on the stb/ack stream fabric.
// Four rounding modes, signed/unsigned saturation and {invalid, inexact} flags.
module float_to_int_rnd #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic [1:0]             input_rm,
    input  logic                   input_signed,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    output logic [INT_W-1:0]       output_z,
    output logic [1:0]             output_flags,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int EW      = EXP_W + 2;
    localparam int RW      = INT_W + MAN_W + 1;
    localparam int CAP     = INT_W + MAN_W + 2;
    localparam int CW      = $clog2(CAP + 1);
    localparam int SH_BASE = INT_W - 1 + MAN_W;

    localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
    localparam logic signed [EW-1:0] E_SUB   = EW'(1 - BIAS);
    localparam logic [INT_W-1:0]     MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0]     MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        GET_A, UNPACK, SPECIAL, ALIGN, ROUND, PACK, PUT_Z
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d, stb_q, stb_d;
    logic [EXP_W+MAN_W:0]    a_q, a_d;
    logic [1:0]              rm_q, rm_d;
    logic                    sg_q, sg_d, neg_q, neg_d;
    logic signed [EW-1:0]    e_q, e_d;
    logic [MAN_W:0]          m_q, m_d;
    logic [RW-1:0]           r_q, r_d;
    logic                    g_q, g_d, s_q, s_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [INT_W:0]          mag_q, mag_d;
    logic                    inx_q, inx_d;
    logic [INT_W-1:0]        z_q, z_d;
    logic [1:0]              flags_q, flags_d;

    logic [EXP_W-1:0]        exp_s;
    logic [MAN_W-1:0]        frac_s;
    logic signed [31:0]      e_ext_s, sh_s;
    logic                    is_nan_s, is_inf_s, is_big_s, is_zero_s;
    logic                    inc_s, ovf_sgn_s, ovf_uns_s, ovf_s;

    function automatic logic [INT_W-1:0] saturate(input logic sg, input logic neg);
        logic [INT_W-1:0] v;
        if (sg) begin
            v = neg ? MIN_NEG : MAX_POS;
        end else begin
            v = neg ? {INT_W{1'b0}} : {INT_W{1'b1}};
        end
        return v;
    endfunction

    assign exp_s     = a_q[EXP_W+MAN_W-1:MAN_W];
    assign frac_s    = a_q[MAN_W-1:0];
    assign e_ext_s   = {{(32-EW){e_q[EW-1]}}, e_q};
    // Right-shift distance that brings the 2^0 weight onto bit 0 of r.
    assign sh_s      = SH_BASE - e_ext_s;
    assign is_nan_s  = (exp_s == {EXP_W{1'b1}}) && (frac_s != {MAN_W{1'b0}});
    assign is_inf_s  = (exp_s == {EXP_W{1'b1}}) && (frac_s == {MAN_W{1'b0}});
    assign is_big_s  = (e_ext_s >= INT_W);
    assign is_zero_s = (exp_s == {EXP_W{1'b0}}) && (frac_s == {MAN_W{1'b0}});

    assign ovf_sgn_s = neg_q ? (mag_q[INT_W] | (mag_q[INT_W-1] & (|mag_q[INT_W-2:0])))
                             : (mag_q[INT_W] | mag_q[INT_W-1]);
    assign ovf_uns_s = mag_q[INT_W] | (neg_q & (|mag_q[INT_W-1:0]));
    assign ovf_s     = sg_q ? ovf_sgn_s : ovf_uns_s;

    assign input_a_ack  = ack_q;
    assign output_z_stb = stb_q;
    assign output_z     = z_q;
    assign output_flags = flags_q;

    // Rounding increment decision from guard, sticky, LSB and sign.
    always_comb begin
        inc_s = 1'b0;
        case (rm_q)
            2'b00:   inc_s = g_q & (s_q | r_q[0]);
            2'b01:   inc_s = 1'b0;
            2'b10:   inc_s = neg_q & (g_q | s_q);
            2'b11:   inc_s = ~neg_q & (g_q | s_q);
            default: inc_s = 1'b0;
        endcase
    end

    // State register and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:   state_d = (ack_q && input_a_stb) ? UNPACK : GET_A;
            UNPACK:  state_d = SPECIAL;
            SPECIAL: state_d = (is_nan_s || is_inf_s || is_big_s || is_zero_s) ? PUT_Z : ALIGN;
            ALIGN:   state_d = (cnt_q == {CW{1'b0}}) ? ROUND : ALIGN;
            ROUND:   state_d = PACK;
            PACK:    state_d = PUT_Z;
            PUT_Z:   state_d = (stb_q && output_z_ack) ? GET_A : PUT_Z;
            default: state_d = GET_A;
        endcase
    end

    // Handshake outputs, registered; ack waits one cycle after entering get_a.
    always_comb begin
        ack_d = (state_q == GET_A) && (state_d == GET_A);
        stb_d = (state_d == PUT_Z);
    end

    // Datapath next-state per conversion step.
    always_comb begin
        a_d = a_q;   rm_d = rm_q;   sg_d = sg_q;   neg_d = neg_q;
        e_d = e_q;   m_d = m_q;     r_d = r_q;     g_d = g_q;
        s_d = s_q;   cnt_d = cnt_q; mag_d = mag_q; inx_d = inx_q;
        z_d = z_q;   flags_d = flags_q;
        case (state_q)
            GET_A: begin
                if (ack_q && input_a_stb) begin
                    a_d  = input_a;
                    rm_d = input_rm;
                    sg_d = input_signed;
                end else begin
                    a_d  = a_q;
                end
            end
            UNPACK: begin
                neg_d = a_q[EXP_W+MAN_W];
                e_d   = (exp_s == {EXP_W{1'b0}}) ? E_SUB : (signed'({2'b00, exp_s}) - BIAS_E);
                m_d   = {(exp_s != {EXP_W{1'b0}}), frac_s};
            end
            SPECIAL: begin
                if (is_nan_s) begin
                    z_d     = sg_q ? MAX_POS : {INT_W{1'b1}};
                    flags_d = 2'b10;
                end else if (is_inf_s || is_big_s) begin
                    z_d     = saturate(sg_q, neg_q);
                    flags_d = 2'b10;
                end else if (is_zero_s) begin
                    z_d     = {INT_W{1'b0}};
                    flags_d = 2'b00;
                end else begin
                    r_d   = RW'(m_q) << (INT_W - 1);
                    g_d   = 1'b0;
                    s_d   = 1'b0;
                    cnt_d = (sh_s > CAP) ? CW'(CAP) : sh_s[CW-1:0];
                end
            end
            ALIGN: begin
                if (cnt_q != {CW{1'b0}}) begin
                    r_d   = r_q >> 1;
                    g_d   = r_q[0];
                    s_d   = s_q | g_q;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ROUND: begin
                mag_d = {1'b0, r_q[INT_W-1:0]} + {{INT_W{1'b0}}, inc_s};
                inx_d = g_q | s_q;
            end
            PACK: begin
                if (ovf_s) begin
                    z_d     = saturate(sg_q, neg_q);
                    flags_d = 2'b10;
                end else begin
                    z_d     = neg_q ? (-mag_q[INT_W-1:0]) : mag_q[INT_W-1:0];
                    flags_d = {1'b0, inx_q};
                end
            end
            PUT_Z: begin
                z_d = z_q;
            end
            default: begin
                z_d = z_q;
            end
        endcase
    end

    // Datapath registers; contents are don't-care across reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;   rm_q  <= rm_d;  sg_q   <= sg_d;  neg_q <= neg_d;
        e_q   <= e_d;   m_q   <= m_d;   r_q    <= r_d;   g_q   <= g_d;
        s_q   <= s_d;   cnt_q <= cnt_d; mag_q  <= mag_d; inx_q <= inx_d;
        z_q   <= z_d;   flags_q <= flags_d;
    end

endmodule

// File: tb/tb_float_to_int_rnd.sv
// Bench for float_to_int_rnd: directed corner cases, handshake/reset behaviour,
// a double-precision instance, and random float32 operands against a real-valued model.
module tb_float_to_int_rnd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a32;
    logic [63:0] a64;
    logic [1:0]  rm_s;
    logic        sg_s;
    logic        stb32, stb64, ack32, ack64;
    logic [31:0] z32;
    logic [63:0] z64;
    logic [1:0]  fl32, fl64;
    logic        zstb32, zstb64, zack32, zack64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_to_int_rnd u_dut (
        .clk(clk), .rst(rst), .input_a(a32), .input_rm(rm_s), .input_signed(sg_s),
        .input_a_stb(stb32), .input_a_ack(ack32), .output_z(z32), .output_flags(fl32),
        .output_z_stb(zstb32), .output_z_ack(zack32)
    );

    float_to_int_rnd #(.EXP_W(11), .MAN_W(52), .INT_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .input_a(a64), .input_rm(rm_s), .input_signed(sg_s),
        .input_a_stb(stb64), .input_a_ack(ack64), .output_z(z64), .output_flags(fl64),
        .output_z_stb(zstb64), .output_z_ack(zack64)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: value as a real, rounded by mode, then range-checked.
    function automatic void ref_model(input logic [31:0] a, input logic [1:0] rm, input logic sg,
                                      output logic [31:0] z, output logic [1:0] fl);
        int     ex;
        int     fr;
        logic   neg, inc, inexact;
        real    mag, ip, f;
        longint r;
        logic   sat;
        ex  = int'(a[30:23]);
        fr  = int'(a[22:0]);
        neg = a[31];
        if (ex == 255 && fr != 0) begin
            z  = sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            fl = 2'b10;
            return;
        end
        if (ex == 0) mag = real'(fr) * (2.0 ** (-149.0));
        else         mag = (8388608.0 + real'(fr)) * (2.0 ** (real'(ex) - 150.0));
        sat = (ex == 255) || (mag >= 4294967296.0);
        inexact = 1'b0;
        r = 64'sd0;
        if (!sat) begin
            ip = $floor(mag);
            f  = mag - ip;
            r  = longint'(ip);
            inexact = (f > 0.0);
            case (rm)
                2'b00:   inc = (f > 0.5) || (f == 0.5 && r[0]);
                2'b01:   inc = 1'b0;
                2'b10:   inc = neg && inexact;
                default: inc = !neg && inexact;
            endcase
            if (inc) r = r + 64'sd1;
            if (sg) sat = neg ? (r > 64'sh8000_0000) : (r > 64'sh7FFF_FFFF);
            else    sat = (r >= 64'sh1_0000_0000) || (neg && r != 64'sd0);
        end
        if (sat) begin
            if (sg) z = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else    z = neg ? 32'h0000_0000 : 32'hFFFF_FFFF;
            fl = 2'b10;
        end else begin
            z  = neg ? 32'(-r) : 32'(r);
            fl = {1'b0, inexact};
        end
    endfunction

    task automatic send32(input logic [31:0] a, input logic [1:0] rm, input logic sg);
        int n;
        @(negedge clk);
        a32 = a; rm_s = rm; sg_s = sg; stb32 = 1'b1;
        n = 0;
        while (!ack32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_ack", 64'(ack32), 64'd1);
        @(negedge clk);
        stb32 = 1'b0;
    endtask

    task automatic wait32(output logic [31:0] z, output logic [1:0] fl);
        int n;
        n = 0;
        while (!zstb32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("out_stb", 64'(zstb32), 64'd1);
        z = z32; fl = fl32;
    endtask

    task automatic finish32();
        zack32 = 1'b1;
        @(negedge clk);
        zack32 = 1'b0;
        check_eq("stb_drop", 64'(zstb32), 64'd0);
    endtask

    task automatic conv64(input logic [63:0] a, input logic sg, input logic [63:0] ez,
                          input logic [1:0] efl);
        int n;
        @(negedge clk);
        a64 = a; rm_s = 2'b00; sg_s = sg; stb64 = 1'b1;
        n = 0;
        while (!ack64 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        stb64 = 1'b0;
        n = 0;
        while (!zstb64 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("d_stb", 64'(zstb64), 64'd1);
        check_eq("d_z", z64, ez);
        check_eq("d_flags", 64'(fl64), 64'(efl));
        zack64 = 1'b1;
        @(negedge clk);
        zack64 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  rm;
        logic        sg;
        logic [31:0] z;
        logic [1:0]  fl;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] got_z, exp_z, a_r;
    logic [1:0]  got_fl, exp_fl;
    logic        seen;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h3FC0_0000, 2'd0, 1'b1, 32'h0000_0002, 2'b01};
        vecs[1]  = '{32'h3FC0_0000, 2'd1, 1'b1, 32'h0000_0001, 2'b01};
        vecs[2]  = '{32'hC020_0000, 2'd0, 1'b1, 32'hFFFF_FFFE, 2'b01};
        vecs[3]  = '{32'hC020_0000, 2'd2, 1'b1, 32'hFFFF_FFFD, 2'b01};
        vecs[4]  = '{32'hC020_0000, 2'd3, 1'b1, 32'hFFFF_FFFE, 2'b01};
        vecs[5]  = '{32'h4F00_0000, 2'd0, 1'b1, 32'h7FFF_FFFF, 2'b10};
        vecs[6]  = '{32'h4F00_0000, 2'd0, 1'b0, 32'h8000_0000, 2'b00};
        vecs[7]  = '{32'hCF00_0000, 2'd0, 1'b1, 32'h8000_0000, 2'b00};
        vecs[8]  = '{32'h7FC0_0000, 2'd0, 1'b1, 32'h7FFF_FFFF, 2'b10};
        vecs[9]  = '{32'hFF80_0000, 2'd0, 1'b0, 32'h0000_0000, 2'b10};
        vecs[10] = '{32'hBF00_0000, 2'd0, 1'b0, 32'h0000_0000, 2'b01};
        vecs[11] = '{32'hBF80_0000, 2'd0, 1'b0, 32'h0000_0000, 2'b10};
        vecs[12] = '{32'h0000_0001, 2'd3, 1'b0, 32'h0000_0001, 2'b01};
        vecs[13] = '{32'h8000_0000, 2'd0, 1'b1, 32'h0000_0000, 2'b00};

        rst = 1'b1; a32 = 32'd0; a64 = 64'd0; rm_s = 2'd0; sg_s = 1'b0;
        stb32 = 1'b0; stb64 = 1'b0; zack32 = 1'b0; zack64 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_stb", 64'(zstb32), 64'd0);
        check_eq("rst_ack", 64'(ack32), 64'd0);
        check_eq("rst_stb64", 64'(zstb64), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ack_rise", 64'(ack32), 64'd1);

        for (int i = 0; i < 14; i++) begin
            send32(vecs[i].a, vecs[i].rm, vecs[i].sg);
            wait32(got_z, got_fl);
            check_eq($sformatf("dir%0d_z", i), 64'(got_z), 64'(vecs[i].z));
            check_eq($sformatf("dir%0d_fl", i), 64'(got_fl), 64'(vecs[i].fl));
            finish32();
        end

        // Backpressure: result must stay put while output_z_ack is low.
        send32(32'hC020_0000, 2'd2, 1'b1);
        wait32(got_z, got_fl);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_stb", 64'(zstb32), 64'd1);
            check_eq("hold_z", 64'(z32), 64'hFFFF_FFFD);
            check_eq("hold_fl", 64'(fl32), 64'd1);
            check_eq("hold_ack", 64'(ack32), 64'd0);
        end
        finish32();

        // Reset in the middle of alignment drops the transaction.
        send32(32'h3FC0_0000, 2'd0, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen = seen | zstb32;
        end
        check_eq("rst_abort", 64'(seen), 64'd0);
        send32(32'h3FC0_0000, 2'd0, 1'b1);
        wait32(got_z, got_fl);
        check_eq("post_rst_z", 64'(got_z), 64'd2);
        check_eq("post_rst_fl", 64'(got_fl), 64'd1);
        finish32();

        conv64(64'hC3E0_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 2'b00);
        conv64(64'h43E0_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10);

        for (int i = 0; i < 400; i++) begin
            logic [7:0]  ex;
            logic [22:0] fr;
            logic [1:0]  rm;
            logic        sg;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ex = 8'd0;
            else if (sel == 1) ex = 8'd255;
            else               ex = 8'($urandom_range(110, 162));
            fr = 23'($urandom());
            if ($urandom_range(0, 2) == 0) fr = fr & 23'h7F_0000;
            rm = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a_r = {1'($urandom_range(0, 1)), ex, fr};
            ref_model(a_r, rm, sg, exp_z, exp_fl);
            send32(a_r, rm, sg);
            wait32(got_z, got_fl);
            check_eq($sformatf("rnd_z a=%h rm=%0d s=%0d", a_r, rm, sg), 64'(got_z), 64'(exp_z));
            check_eq($sformatf("rnd_fl a=%h rm=%0d s=%0d", a_r, rm, sg), 64'(got_fl), 64'(exp_fl));
            finish32();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
